// File: rtl/voice_player.sv
`default_nettype none
// ============================================================================
//  Module   : voice_player
//  Purpose  : Turns tap pulses and the game-over code into timed square-wave
//             tones on one buzzer pin. Macro VOICE_GAMEOVER_MELODY_EN selects
//             the three-note game-over melody; otherwise one long low note.
//  Revision : 1.0  initial release
// ============================================================================
module voice_player #(
    parameter int TAP_CYCLES  = 2_500_000,
    parameter int NOTE_CYCLES = 5_000_000,
    parameter int GAP_CYCLES  = 1_250_000,
    parameter int HALF1       = 23901,
    parameter int HALF2       = 18968,
    parameter int HALF3       = 15944,
    parameter int HALF4       = 31888,
    parameter int HALF5       = 37879,
    parameter int HALF6       = 47710
) (
    input  logic       clk_vga,
    input  logic       game_rst,
    input  logic       voi1,
    input  logic       voi2,
    input  logic       voi3,
    input  logic [1:0] gameover_voi,
    output logic       buzzer,
    output logic       busy,
    output logic [2:0] tone_id
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        TAP      = 2'd1,
        MEL_NOTE = 2'd2,
        MEL_GAP  = 2'd3
    } state_t;

`ifdef VOICE_GAMEOVER_MELODY_EN
    localparam int          NOTE_LEN     = NOTE_CYCLES;
    localparam logic [2:0]  MEL_FIRST_ID = 3'd4;
`else
    localparam int          NOTE_LEN     = 3 * NOTE_CYCLES;
    localparam logic [2:0]  MEL_FIRST_ID = 3'd6;
`endif

    localparam logic [23:0] TAP_LAST  = 24'(TAP_CYCLES - 1);
    localparam logic [23:0] NOTE_LAST = 24'(NOTE_LEN - 1);
    localparam logic [23:0] GAP_LAST  = 24'(GAP_CYCLES - 1);

    state_t      state_q, state_d;
    logic [23:0] dur_cnt_q, dur_cnt_d;
    logic [15:0] half_cnt_q, half_cnt_d;
    logic        buzzer_q, buzzer_d;
    logic        busy_q, busy_d;
    logic [2:0]  tone_id_q, tone_id_d;
`ifdef VOICE_GAMEOVER_MELODY_EN
    logic [1:0]  note_no_q, note_no_d;
`endif

    logic [15:0] half_last;
    logic        half_wrap;
    logic        tap_any;
    logic [2:0]  tap_id;

    // tone_id uniquely identifies the pitch, so it also selects the half-period
    always_comb begin
        case (tone_id_q)
            3'd1:    half_last = 16'(HALF1 - 1);
            3'd2:    half_last = 16'(HALF2 - 1);
            3'd3:    half_last = 16'(HALF3 - 1);
            3'd4:    half_last = 16'(HALF4 - 1);
            3'd5:    half_last = 16'(HALF5 - 1);
            3'd6:    half_last = 16'(HALF6 - 1);
            default: half_last = 16'd0;
        endcase
    end

    assign half_wrap = (half_cnt_q == half_last);
    assign tap_any   = voi1 | voi2 | voi3;
    assign tap_id    = voi1 ? 3'd1 : (voi2 ? 3'd2 : 3'd3);

    always_comb begin
        state_d    = state_q;
        dur_cnt_d  = dur_cnt_q;
        half_cnt_d = half_cnt_q;
        buzzer_d   = buzzer_q;
        tone_id_d  = tone_id_q;
`ifdef VOICE_GAMEOVER_MELODY_EN
        note_no_d  = note_no_q;
`endif

        if (gameover_voi == 2'd1) begin
            state_d    = MEL_NOTE;
            tone_id_d  = MEL_FIRST_ID;
            dur_cnt_d  = 24'd0;
            half_cnt_d = 16'd0;
            buzzer_d   = 1'b0;
`ifdef VOICE_GAMEOVER_MELODY_EN
            note_no_d  = 2'd0;
`endif
        end else if (tap_any && (state_q == IDLE || state_q == TAP)) begin
            state_d    = TAP;
            tone_id_d  = tap_id;
            dur_cnt_d  = 24'd0;
            half_cnt_d = 16'd0;
            buzzer_d   = 1'b0;
        end else begin
            case (state_q)
                TAP: begin
                    if (dur_cnt_q == TAP_LAST) begin
                        state_d    = IDLE;
                        tone_id_d  = 3'd0;
                        dur_cnt_d  = 24'd0;
                        half_cnt_d = 16'd0;
                        buzzer_d   = 1'b0;
                    end else begin
                        dur_cnt_d  = dur_cnt_q + 24'd1;
                        half_cnt_d = half_wrap ? 16'd0 : half_cnt_q + 16'd1;
                        buzzer_d   = buzzer_q ^ half_wrap;
                    end
                end
                MEL_NOTE: begin
                    if (dur_cnt_q == NOTE_LAST) begin
                        state_d    = IDLE;
                        tone_id_d  = 3'd0;
                        dur_cnt_d  = 24'd0;
                        half_cnt_d = 16'd0;
                        buzzer_d   = 1'b0;
`ifdef VOICE_GAMEOVER_MELODY_EN
                        if (note_no_q < 2'd2) begin
                            state_d = MEL_GAP;
                        end
`endif
                    end else begin
                        dur_cnt_d  = dur_cnt_q + 24'd1;
                        half_cnt_d = half_wrap ? 16'd0 : half_cnt_q + 16'd1;
                        buzzer_d   = buzzer_q ^ half_wrap;
                    end
                end
                MEL_GAP: begin
                    if (dur_cnt_q == GAP_LAST) begin
                        dur_cnt_d = 24'd0;
`ifdef VOICE_GAMEOVER_MELODY_EN
                        state_d   = MEL_NOTE;
                        note_no_d = note_no_q + 2'd1;
                        tone_id_d = 3'd5 + {1'b0, note_no_q};
`else
                        state_d   = IDLE;
                        tone_id_d = 3'd0;
`endif
                    end else begin
                        dur_cnt_d = dur_cnt_q + 24'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_vga or posedge game_rst) begin
        if (game_rst) begin
            state_q    <= IDLE;
            dur_cnt_q  <= 24'd0;
            half_cnt_q <= 16'd0;
            buzzer_q   <= 1'b0;
            busy_q     <= 1'b0;
            tone_id_q  <= 3'd0;
`ifdef VOICE_GAMEOVER_MELODY_EN
            note_no_q  <= 2'd0;
`endif
        end else begin
            state_q    <= state_d;
            dur_cnt_q  <= dur_cnt_d;
            half_cnt_q <= half_cnt_d;
            buzzer_q   <= buzzer_d;
            busy_q     <= busy_d;
            tone_id_q  <= tone_id_d;
`ifdef VOICE_GAMEOVER_MELODY_EN
            note_no_q  <= note_no_d;
`endif
        end
    end

    assign buzzer  = buzzer_q;
    assign busy    = busy_q;
    assign tone_id = tone_id_q;

endmodule
`default_nettype wire
